cpu_control_fsm: RTL
====================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port instr_type, input, 3: decoded class from the instruction decoder.
- 000 ALU (R or immediate)
- 001 STORE
- 010 LOAD
- 011 JCOND
- 100 BCOND
- 101 JAL
- others illegal
REQ-005 Port cond_true, input, 1: current flags satisfy the instruction's condition field.
REQ-006 Port mem_ready, input, 1: memory completed the current access this cycle.
REQ-007 Port ir_en, output, 1: load instruction register.
REQ-008 Port pc_en, output, 1: update PC.
REQ-009 Port pc_src, output, 2: PC source.
- 00 PC+1
- 01 PC+branch displacement
- 10 register target
REQ-010 Port mem_addr_sel, output, 1: memory address source; 0 = PC, 1 = register.
REQ-011 Port mem_we, output, 1: memory write strobe.
REQ-012 Port reg_we, output, 1: register file write enable.
REQ-013 Port wb_sel, output, 2: write-back source; 00 = ALU, 01 = memory, 10 = PC+1 link.
REQ-014 Port flags_en, output, 1: latch ALU flags.
REQ-015 Port state, output, 3: current state encoding, for debug.
REQ-016 Port retired, output, CNT_W: count of completed instructions.

Function
REQ-017 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; all outputs SHALL be Moore/Mealy-combinational from state, instr_type, cond_true, mem_ready, and SHALL be 0 unless stated.
REQ-018 FETCH: mem_addr_sel=0; when mem_ready=1, ir_en=1 for that cycle and next state DECODE; otherwise remain in FETCH.
REQ-019 DECODE: no strobes; next state EXEC unconditionally (one cycle for decoder settle).
REQ-020 EXEC for ALU: reg_we=1, wb_sel=00, flags_en=1, pc_en=1, pc_src=00; next state FETCH.
REQ-021 EXEC for LOAD/STORE: no strobes; next state MEM.
REQ-022 EXEC for JCOND: pc_en=1, pc_src=10 if cond_true else 00; next state FETCH.
REQ-023 EXEC for BCOND: pc_en=1, pc_src=01 if cond_true else 00; next state FETCH.
REQ-024 EXEC for JAL: reg_we=1, wb_sel=10, pc_en=1, pc_src=10; next state FETCH.
REQ-025 EXEC for an illegal type: pc_en=1, pc_src=00, no other strobes (NOP); next state FETCH.
REQ-026 MEM: mem_addr_sel=1; mem_we=1 throughout when STORE; hold MEM while mem_ready=0.
- STORE, on mem_ready=1: pc_en=1, pc_src=00; next state FETCH.
- LOAD, on mem_ready=1: next state WB.
REQ-027 WB: reg_we=1, wb_sel=01, pc_en=1, pc_src=00; next state FETCH.
REQ-028 With mem_ready held 1, latency SHALL be 3 cycles for ALU/branch/JAL/NOP, 4 for STORE and 5 for LOAD, FETCH to FETCH.
REQ-029 Each mem_ready=0 cycle in FETCH or MEM SHALL add exactly one cycle.
REQ-030 pc_en SHALL pulse exactly once per instruction.
REQ-031 retired SHALL increment by 1 in the cycle after each pc_en pulse, wrapping from all-ones to 0.
REQ-032 reg_we and mem_we SHALL never be asserted in the same cycle.
REQ-033 mem_we SHALL never assert outside MEM.
REQ-034 instr_type SHALL be sampled only in EXEC, MEM and WB; changes in FETCH or DECODE have no effect.

Reset
REQ-035 While reset=1 at a clock edge, the block SHALL enter state FETCH and clear retired to 0.
REQ-036 While the FSM is in FETCH after reset, all strobes SHALL be 0 until mem_ready is sampled.
REQ-037 Reset asserted in any state, including MEM during a stalled store, SHALL drop mem_we, reg_we and pc_en from the next cycle, with no partial write-back.
REQ-038 Reset SHALL take priority over all transitions.

Verification
REQ-039 Reset, mem_ready=1, instr_type=000 -> state 0,1,2,0; ir_en in cycle 0; reg_we=flags_en=pc_en=1 in cycle 2; retired=1.
REQ-040 LOAD with mem_ready low 2 cycles in MEM -> MEM held 3 cycles; then WB with reg_we=1, wb_sel=01; total 7 cycles; mem_we never 1.
REQ-041 STORE, mem_ready=1 -> mem_we=1, mem_addr_sel=1 for exactly 1 cycle in MEM; pc_en same cycle; 4 cycles.
REQ-042 BCOND with cond_true=1, then cond_true=0 -> pc_src=01, then 00; JCOND with cond_true=1 -> pc_src=10; JAL -> reg_we=1, wb_sel=10, pc_src=10.
REQ-043 Reset pulse during a stalled STORE in MEM -> mem_we=0 on the next cycle, state=0, retired=0.
REQ-044 Preload the counter near wrap (CNT_W=4), run 16 ALU instructions -> retired wraps 15 to 0; illegal instr_type=111 -> NOP, pc_src=00.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Multi-cycle CPU sequencer: FETCH -> DECODE -> EXEC -> (MEM -> (WB)) -> FETCH.
//   All strobes are combinational from the current state and the live inputs.
//   A retired-instruction counter advances once per instruction, on the cycle
//   after the PC update.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   instr_type   in   [2:0] decoded class (ALU/STORE/LOAD/JCOND/BCOND/JAL)
//   cond_true    in   instruction condition satisfied by current flags
//   mem_ready    in   memory finished the current access this cycle
//   ir_en        out  load instruction register
//   pc_en        out  update PC (one pulse per instruction)
//   pc_src       out  [1:0] 00 PC+1, 01 PC+disp, 10 register target
//   mem_addr_sel out  0 = PC, 1 = register
//   mem_we       out  memory write strobe
//   reg_we       out  register file write enable
//   wb_sel       out  [1:0] 00 ALU, 01 memory, 10 PC+1 link
//   flags_en     out  latch ALU flags
//   state        out  [2:0] current state, debug
//   retired      out  [CNT_W-1:0] completed-instruction count
module cpu_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       instr_type,
    input  logic             cond_true,
    input  logic             mem_ready,
    output logic             ir_en,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             mem_addr_sel,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             flags_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] T_ALU   = 3'b000;
    localparam logic [2:0] T_STORE = 3'b001;
    localparam logic [2:0] T_LOAD  = 3'b010;
    localparam logic [2:0] T_JCOND = 3'b011;
    localparam logic [2:0] T_BCOND = 3'b100;
    localparam logic [2:0] T_JAL   = 3'b101;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    state_t cur_state, nxt_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            retired   <= '0;
        end else begin
            cur_state <= nxt_state;
            if (pc_en)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_INC;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        flags_en     = 1'b0;

        case (cur_state)
            FETCH: begin
                if (mem_ready) begin
                    ir_en     = 1'b1;
                    nxt_state = DECODE;
                end
            end

            // One settle cycle for the decoder; instr_type is not looked at.
            DECODE: nxt_state = EXEC;

            EXEC: begin
                nxt_state = FETCH;
                case (instr_type)
                    T_ALU: begin
                        reg_we   = 1'b1;
                        wb_sel   = WB_ALU;
                        flags_en = 1'b1;
                        pc_en    = 1'b1;
                    end
                    T_STORE, T_LOAD: nxt_state = MEM;
                    T_JCOND: begin
                        pc_en  = 1'b1;
                        pc_src = cond_true ? PC_REG : PC_INC;
                    end
                    T_BCOND: begin
                        pc_en  = 1'b1;
                        pc_src = cond_true ? PC_BR : PC_INC;
                    end
                    T_JAL: begin
                        reg_we = 1'b1;
                        wb_sel = WB_LINK;
                        pc_en  = 1'b1;
                        pc_src = PC_REG;
                    end
                    // Illegal classes retire as a NOP.
                    default: pc_en = 1'b1;
                endcase
            end

            MEM: begin
                mem_addr_sel = 1'b1;
                mem_we       = (instr_type == T_STORE);
                if (mem_ready) begin
                    if (instr_type == T_LOAD) begin
                        nxt_state = WB;
                    end else begin
                        // Store completes here; any other class seen in MEM
                        // is retired the same way so pc_en still pulses once.
                        pc_en     = 1'b1;
                        nxt_state = FETCH;
                    end
                end
            end

            WB: begin
                reg_we    = 1'b1;
                wb_sel    = WB_MEM;
                pc_en     = 1'b1;
                nxt_state = FETCH;
            end

            default: nxt_state = FETCH;
        endcase
    end

    assign state = cur_state;

endmodule
